// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl
// Purpose  : Execute-stage branch sequencer. It accepts a branch or jump from
//            decode and drives BrUn to the shared comparator. One cycle later
//            it samples BrEq/BrLT and resolves the branch as taken or not
//            taken (static not-taken fetch policy). A taken branch issues a
//            PC redirect and holds flush for FLUSH_CYCLES cycles. Saturating
//            counters track resolved and taken branches.
// Ports    : clk, rst_n           clock, synchronous active-low reset
//            br_valid/br_ready    decode handshake (ready only in IDLE)
//            br_funct3/br_is_jump branch kind (funct3 ignored for jumps)
//            br_target            resolved target address
//            stall                freezes capture and resolution
//            BrUn / BrEq / BrLT   comparator control and results
//            pc_sel/redirect_pc   fetch redirect (pulse / held target)
//            flush                kill younger instructions
//            resolve_valid/taken  resolution pulse and its outcome
//            illegal              pulse on reserved funct3 (010/011)
//            branch_cnt/taken_cnt saturating statistics
// Revision : 1.0  initial release
// ============================================================================
module branch_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic             br_is_jump,
  input  logic [XLEN-1:0]  br_target,
  input  logic             stall,
  output logic             BrUn,
  input  logic             BrEq,
  input  logic             BrLT,
  output logic             pc_sel,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             resolve_valid,
  output logic             resolve_taken,
  output logic             illegal,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  localparam logic [3:0]       C_FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nx;
  logic [2:0]        r_funct3;
  logic              r_is_jump;
  logic [XLEN-1:0]   r_target;
  logic [3:0]        r_flush_cnt;
  logic [3:0]        w_flush_cnt_nx;
  logic              r_brun;
  logic              r_pc_sel;
  logic [XLEN-1:0]   r_redirect_pc;
  logic              r_flush;
  logic              r_resolve_valid;
  logic              r_resolve_taken;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_branch_cnt;
  logic [CNT_W-1:0]  r_taken_cnt;

  logic              w_capture;
  logic              w_resolve;
  logic              w_taken;
  logic              w_illegal;
  logic              w_flush_nx;
  logic              w_pc_sel_nx;

  // Outcome decode from the captured instruction and the live comparator.
  // Signed/unsigned pairs share one decode: BrUn already selected the
  // comparison flavour while in RESOLVE.
  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    if (r_is_jump) begin
      w_taken = 1'b1;
    end else begin
      case (r_funct3)
        3'b000:         w_taken = BrEq;
        3'b001:         w_taken = ~BrEq;
        3'b100, 3'b110: w_taken = BrLT;
        3'b101, 3'b111: w_taken = ~BrLT;
        default:        w_illegal = 1'b1;
      endcase
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx     = r_state;
    w_flush_cnt_nx = r_flush_cnt;
    w_flush_nx     = r_flush;
    w_pc_sel_nx    = 1'b0;
    w_capture      = 1'b0;
    w_resolve      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (br_valid && !stall) begin
          w_capture  = 1'b1;
          w_state_nx = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (!stall) begin
          w_resolve = 1'b1;
          if (w_taken) begin
            w_state_nx     = S_FLUSH;
            w_flush_cnt_nx = C_FLUSH_LOAD;
            w_flush_nx     = 1'b1;
            w_pc_sel_nx    = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        // Flush runs down unconditionally; a stall cannot extend it.
        if (r_flush_cnt <= 4'd1) begin
          w_state_nx     = S_IDLE;
          w_flush_cnt_nx = 4'd0;
          w_flush_nx     = 1'b0;
        end else begin
          w_flush_cnt_nx = r_flush_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nx     = S_IDLE;
        w_flush_cnt_nx = 4'd0;
        w_flush_nx     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_funct3        <= 3'd0;
      r_is_jump       <= 1'b0;
      r_target        <= '0;
      r_flush_cnt     <= 4'd0;
      r_brun          <= 1'b0;
      r_pc_sel        <= 1'b0;
      r_redirect_pc   <= '0;
      r_flush         <= 1'b0;
      r_resolve_valid <= 1'b0;
      r_resolve_taken <= 1'b0;
      r_illegal       <= 1'b0;
      r_branch_cnt    <= '0;
      r_taken_cnt     <= '0;
    end else begin
      r_state         <= w_state_nx;
      r_flush_cnt     <= w_flush_cnt_nx;
      r_flush         <= w_flush_nx;
      r_pc_sel        <= w_pc_sel_nx;
      r_resolve_valid <= w_resolve;
      r_resolve_taken <= w_resolve & w_taken;
      r_illegal       <= w_resolve & w_illegal;
      if (w_capture) begin
        r_funct3  <= br_funct3;
        r_is_jump <= br_is_jump;
        r_target  <= br_target;
        // Registered at capture so the comparator sees it for all of RESOLVE.
        r_brun    <= br_funct3[1] & ~br_is_jump;
      end
      if (w_resolve && w_taken) begin
        r_redirect_pc <= r_target;
      end
      if (w_resolve) begin
        if (r_branch_cnt != C_CNT_MAX) begin
          r_branch_cnt <= r_branch_cnt + C_CNT_ONE;
        end
        if (w_taken && (r_taken_cnt != C_CNT_MAX)) begin
          r_taken_cnt <= r_taken_cnt + C_CNT_ONE;
        end
      end
    end
  end

  assign br_ready      = (r_state == S_IDLE);
  assign BrUn          = r_brun;
  assign pc_sel        = r_pc_sel;
  assign redirect_pc   = r_redirect_pc;
  assign flush         = r_flush;
  assign resolve_valid = r_resolve_valid;
  assign resolve_taken = r_resolve_taken;
  assign illegal       = r_illegal;
  assign branch_cnt    = r_branch_cnt;
  assign taken_cnt     = r_taken_cnt;

endmodule
`default_nettype wire

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequencer for the execute-stage branch comparator.
- Accepts branch/jump instructions from decode and drives BrUn to the comparator.
- Samples BrEq/BrLT one cycle later, decides taken/not-taken under a static not-taken policy, and issues the PC redirect plus a multi-cycle pipeline flush.
- Keeps saturating branch/taken statistics counters.

Parameters:
- XLEN, 32, datapath/PC width.
- FLUSH_CYCLES, 2, cycles flush is held after a taken redirect (legal range 1..15).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- br_valid  in  1  decode presents a branch/jump this cycle.
- br_ready  out  1  controller can accept; equals (state==IDLE).
- br_funct3  in  3  B-type funct3 (ignored for jumps).
- br_is_jump  in  1  JAL/JALR: unconditionally taken.
- br_target  in  XLEN  resolved target address.
- stall  in  1  pipeline stall; freezes capture and resolution.
- BrUn  out  1  to comparator: 1 = unsigned compare.
- BrEq  in  1  from comparator.
- BrLT  in  1  from comparator.
- pc_sel  out  1  one-cycle pulse: fetch takes redirect_pc.
- redirect_pc  out  XLEN  registered target; holds last value.
- flush  out  1  kill younger instructions.
- resolve_valid  out  1  one-cycle pulse, branch resolved.
- resolve_taken  out  1  outcome, valid with resolve_valid.
- illegal  out  1  one-cycle pulse, illegal funct3 (010/011).
- branch_cnt  out  CNT_W  resolved branches, saturating.
- taken_cnt  out  CNT_W  taken branches, saturating.

Behaviour:
- Reset (rst_n=0 at an edge, any state): state=IDLE, flush counter=0. Every output and counter is 0, except br_ready, which is 1 once in IDLE. Reset mid-RESOLVE/FLUSH abandons the branch with no pc_sel, resolve_valid or counter update.
- All outputs are registered except br_ready (decoded from state).
- Acceptance in IDLE:
  - Condition: br_valid & ~stall at edge T.
  - Captures funct3, is_jump and target; moves to RESOLVE.
  - BrUn is registered as funct3[1] & ~is_jump, so it is valid throughout RESOLVE.
- RESOLVE:
  - The datapath holds rs1/rs2 stable at the comparator.
  - If stall: hold, no sampling.
  - Otherwise sample at edge T+1 and compute taken:
    - BEQ 000: BrEq.
    - BNE 001: ~BrEq.
    - BLT 100: BrLT.
    - BGE 101: ~BrLT.
    - BLTU 110: BrLT.
    - BGEU 111: ~BrLT.
    - Jump: 1.
    - 010/011: taken=0, plus an illegal pulse.
- Results visible from T+2:
  - resolve_valid=1 and resolve_taken=taken for one cycle.
  - branch_cnt increments by 1.
  - taken_cnt increments if taken.
  - Counters saturate at 2^CNT_W-1; no wrap.
- Not taken: return to IDLE at T+2, so br_ready=1 in T+2 and the next branch can be captured at edge T+2.
- Taken:
  - Enter FLUSH at T+2.
  - redirect_pc=target loaded at the same edge.
  - pc_sel=1 in the first FLUSH cycle only.
  - flush=1 for exactly FLUSH_CYCLES cycles (T+2 .. T+1+FLUSH_CYCLES).
  - Counter decrements every cycle regardless of stall.
  - Returns to IDLE after the last flush cycle.
- FLUSH state: br_valid is ignored (wrong-path instruction); br_ready=0.
- br_valid with stall=1 in IDLE: not captured; decode must hold.
- BrUn holds its last value in IDLE/FLUSH; it is cleared only by reset.
- Illegal funct3 never redirects and never asserts flush.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> all outputs 0, br_ready=1, counters 0.
- BEQ (funct3=000), target=0x0000_0100, BrEq=1 in RESOLVE:
  - T+2: pc_sel=1, redirect_pc=0x100, resolve_taken=1.
  - flush high for 2 cycles.
  - branch_cnt=1, taken_cnt=1.
- BLTU (110), rs1=0xFFFF_FFFF, rs2=1, comparator gives BrLT=0 with BrUn=1 -> BrUn=1 during RESOLVE, resolve_taken=0, no pc_sel/flush. A second BGE captured at T+2 resolves at T+4.
- BLT signed (100) with stall=1 for 3 cycles in RESOLVE and BrLT=1 after -> no resolve during stall; pc_sel one cycle after stall drops. br_valid pulses during FLUSH produce no second resolve.
- funct3=010 -> illegal=1 for one cycle, resolve_taken=0, branch_cnt increments, no flush.
- CNT_W=4, 20 taken JALs -> branch_cnt=taken_cnt=15 (saturated). Assert rst_n=0 mid-FLUSH -> flush drops next cycle and counters read 0.
